// File: rtl/dpram_port_arbiter.sv
`default_nettype none
// ============================================================================
// dpram_port_arbiter: round-robin sharing of a dual-port RAM among requesters
// Revision: 1.0
// ============================================================================
module dpram_port_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 6,
    parameter int DW   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ-1:0]     req_we,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*DW-1:0]  req_wdata,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [NREQ*DW-1:0]  rsp_data,
    output logic [AW-1:0]       ram_addr_a,
    output logic [AW-1:0]       ram_addr_b,
    output logic [DW-1:0]       ram_data_a,
    output logic [DW-1:0]       ram_data_b,
    output logic                ram_we_a,
    output logic                ram_we_b,
    input  logic [DW-1:0]       ram_q_a,
    input  logic [DW-1:0]       ram_q_b,
    output logic [15:0]         conflict_cnt
);

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    logic [1:0]    r_ptr;
    logic          r_own_a_vld;
    logic [1:0]    r_own_a_tag;
    logic          r_own_b_vld;
    logic [1:0]    r_own_b_tag;
    logic [15:0]   r_conflict_cnt;

    logic [AW-1:0] w_addr  [NREQ];
    logic [DW-1:0] w_wdata [NREQ];

    logic          w_a_vld;
    logic [1:0]    w_a_idx;
    logic          w_b_cand;
    logic [1:0]    w_b_idx;
    logic          w_hazard;
    logic          w_b_vld;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_addr[gi]  = req_addr[AW*gi +: AW];
            assign w_wdata[gi] = req_wdata[DW*gi +: DW];
        end
    endgenerate

    // Descending scan: the last hit wins, which is the first valid in ptr order.
    always_comb begin
        w_a_vld = 1'b0;
        w_a_idx = r_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[r_ptr + 2'(k)]) begin
                w_a_vld = 1'b1;
                w_a_idx = r_ptr + 2'(k);
            end
        end
    end

    always_comb begin
        w_b_cand = 1'b0;
        w_b_idx  = w_a_idx;
        for (int k = NREQ - 1; k >= 1; k--) begin
            if (w_a_vld && req_valid[w_a_idx + 2'(k)]) begin
                w_b_cand = 1'b1;
                w_b_idx  = w_a_idx + 2'(k);
            end
        end
    end

    // Same address on both ports is only safe when both sides read.
    assign w_hazard = w_a_vld && w_b_cand &&
                      (w_addr[w_a_idx] == w_addr[w_b_idx]) &&
                      (req_we[w_a_idx] || req_we[w_b_idx]);
    assign w_b_vld  = w_b_cand && !w_hazard;

    always_comb begin
        req_ready = '0;
        if (w_a_vld) begin
            req_ready[w_a_idx] = 1'b1;
        end
        if (w_b_vld) begin
            req_ready[w_b_idx] = 1'b1;
        end
    end

    always_comb begin
        ram_addr_a = '0;
        ram_data_a = '0;
        ram_we_a   = 1'b0;
        ram_addr_b = '0;
        ram_data_b = '0;
        ram_we_b   = 1'b0;
        if (w_a_vld) begin
            ram_addr_a = w_addr[w_a_idx];
            ram_data_a = w_wdata[w_a_idx];
            ram_we_a   = req_we[w_a_idx];
        end
        if (w_b_vld) begin
            ram_addr_b = w_addr[w_b_idx];
            ram_data_b = w_wdata[w_b_idx];
            ram_we_b   = req_we[w_b_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr          <= 2'd0;
            r_own_a_vld    <= 1'b0;
            r_own_a_tag    <= 2'd0;
            r_own_b_vld    <= 1'b0;
            r_own_b_tag    <= 2'd0;
            r_conflict_cnt <= 16'd0;
        end else begin
            if (w_a_vld) begin
                r_ptr <= (w_b_vld ? w_b_idx : w_a_idx) + 2'd1;
            end
            r_own_a_vld <= w_a_vld;
            r_own_a_tag <= w_a_idx;
            r_own_b_vld <= w_b_vld;
            r_own_b_tag <= w_b_idx;
            if (w_hazard && (r_conflict_cnt != C_CNT_MAX)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

    // A write response carries the RAM's write-through output, same as a read.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_own_a_vld && (r_own_a_tag == 2'(i))) begin
                rsp_valid[i]         = 1'b1;
                rsp_data[DW*i +: DW] = ram_q_a;
            end
            if (r_own_b_vld && (r_own_b_tag == 2'(i))) begin
                rsp_valid[i]         = 1'b1;
                rsp_data[DW*i +: DW] = ram_q_b;
            end
        end
    end

    assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dpram_port_arbiter.sv
`default_nettype none
// Bench for dpram_port_arbiter: behavioural dual-port RAM plus response scoreboard.
module tb_dpram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_we = '0;
    logic [23:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic [5:0]  ram_addr_a, ram_addr_b;
    logic [7:0]  ram_data_a, ram_data_b;
    logic        ram_we_a, ram_we_b;
    logic [7:0]  ram_q_a = '0;
    logic [7:0]  ram_q_b = '0;
    logic [15:0] conflict_cnt;

    typedef struct {
        int         req;
        logic [7:0] data;
    } exp_t;

    exp_t        pend_q[$];
    exp_t        due_q[$];
    logic [7:0]  mem    [64];
    logic [7:0]  shadow [64];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          sb_en = 1'b1;
    logic [3:0]  exp_v;
    logic [31:0] exp_d;

    dpram_port_arbiter #(.NREQ(4), .AW(6), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
        .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
        .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
        .ram_q_a(ram_q_a), .ram_q_b(ram_q_b),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural 64x8 true dual-port RAM with write-through registered outputs.
    always @(posedge clk) begin
        if (ram_we_a) begin
            mem[ram_addr_a] = ram_data_a;
            ram_q_a = ram_data_a;
        end else begin
            ram_q_a = mem[ram_addr_a];
        end
        if (ram_we_b) begin
            mem[ram_addr_b] = ram_data_b;
            ram_q_b = ram_data_b;
        end else begin
            ram_q_b = mem[ram_addr_b];
        end
    end

    always @(posedge clk) begin
        while (pend_q.size() > 0) due_q.push_back(pend_q.pop_front());
    end

    always @(negedge clk) begin
        if (sb_en) begin
            exp_v = '0;
            exp_d = '0;
            while (due_q.size() > 0) begin
                exp_t e;
                e = due_q.pop_front();
                exp_v[e.req] = 1'b1;
                exp_d[8*e.req +: 8] = e.data;
            end
            n_checks++;
            if (rsp_valid !== exp_v) begin
                $display("FAIL sb_rsp_valid @%0t: got %b expected %b", $time, rsp_valid, exp_v);
                n_fail++;
            end
            n_checks++;
            if (rsp_data !== exp_d) begin
                $display("FAIL sb_rsp_data @%0t: got %h expected %h", $time, rsp_data, exp_d);
                n_fail++;
            end
        end
    end

    task automatic drive(input int r, input bit we, input logic [5:0] a, input logic [7:0] d);
        req_valid[r]       = 1'b1;
        req_we[r]          = we;
        req_addr[6*r +: 6] = a;
        req_wdata[8*r +: 8] = d;
    endtask

    task automatic idle_all();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic expect_acc(input int r, input bit we, input logic [5:0] a, input logic [7:0] d);
        exp_t e;
        e.req = r;
        if (we) begin
            shadow[a] = d;
            e.data = d;
        end else begin
            e.data = shadow[a];
        end
        pend_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_all();
        pend_q.delete();
        due_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 4'b0000) begin $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); n_fail++; end
        n_checks++;
        if (conflict_cnt !== 16'd0) begin $display("FAIL reset_conflict_cnt: got %h expected 0000", conflict_cnt); n_fail++; end
        n_checks++;
        if ({ram_we_a, ram_we_b} !== 2'b00) begin $display("FAIL reset_ram_we: got %b expected 00", {ram_we_a, ram_we_b}); n_fail++; end
        n_checks++;
        if (req_ready !== 4'b0000) begin $display("FAIL reset_ready: got %b expected 0000", req_ready); n_fail++; end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(2, 1'b0, 6'd5, 8'h00);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0100) begin $display("FAIL reset_first_ready: got %b expected 0100", req_ready); n_fail++; end
        expect_acc(2, 1'b0, 6'd5, 8'h00);
        @(posedge clk); #1;
        idle_all();
        n_checks++;
        if (rsp_data[23:16] !== 8'h3C) begin $display("FAIL reset_first_rsp_data: got %h expected 3c", rsp_data[23:16]); n_fail++; end
        @(negedge clk);
    endtask

    task automatic test_dual_grant();
        do_reset();
        drive(0, 1'b1, 6'd1, 8'hA5);
        drive(1, 1'b1, 6'd2, 8'h5A);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0011) begin $display("FAIL dual_ready: got %b expected 0011", req_ready); n_fail++; end
        n_checks++;
        if ({ram_we_a, ram_we_b, ram_addr_a, ram_addr_b} !== {2'b11, 6'd1, 6'd2}) begin
            $display("FAIL dual_ram_drive: got %b%b %0d %0d expected 11 1 2", ram_we_a, ram_we_b, ram_addr_a, ram_addr_b); n_fail++;
        end
        expect_acc(0, 1'b1, 6'd1, 8'hA5);
        expect_acc(1, 1'b1, 6'd2, 8'h5A);
        @(posedge clk); #1;
        idle_all();
        drive(0, 1'b0, 6'd1, 8'h00);
        drive(1, 1'b0, 6'd2, 8'h00);
        drive(2, 1'b0, 6'd5, 8'h00);
        drive(3, 1'b0, 6'd1, 8'h00);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b1100) begin $display("FAIL dual_ptr_is_2: got %b expected 1100", req_ready); n_fail++; end
        expect_acc(2, 1'b0, 6'd5, 8'h00);
        expect_acc(3, 1'b0, 6'd1, 8'h00);
        @(posedge clk); #1;
        req_valid[3:2] = 2'b00;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0011) begin $display("FAIL dual_readback_ready: got %b expected 0011", req_ready); n_fail++; end
        expect_acc(0, 1'b0, 6'd1, 8'h00);
        expect_acc(1, 1'b0, 6'd2, 8'h00);
        @(posedge clk); #1;
        idle_all();
        @(negedge clk);
    endtask

    task automatic test_hazard();
        do_reset();
        drive(0, 1'b1, 6'd9, 8'h9E);
        drive(3, 1'b0, 6'd9, 8'h00);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0001) begin $display("FAIL hazard_ready: got %b expected 0001", req_ready); n_fail++; end
        n_checks++;
        if (ram_we_b !== 1'b0) begin $display("FAIL hazard_port_b_we: got %b expected 0", ram_we_b); n_fail++; end
        expect_acc(0, 1'b1, 6'd9, 8'h9E);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (conflict_cnt !== 16'd1) begin $display("FAIL hazard_conflict_cnt: got %0d expected 1", conflict_cnt); n_fail++; end
        n_checks++;
        if ({req_ready, ram_addr_a, ram_we_a, ram_we_b} !== {4'b1000, 6'd9, 2'b00}) begin
            $display("FAIL hazard_retry_port_a: got ready=%b addr_a=%0d we=%b%b expected ready=1000 addr_a=9 we=00",
                     req_ready, ram_addr_a, ram_we_a, ram_we_b); n_fail++;
        end
        expect_acc(3, 1'b0, 6'd9, 8'h00);
        @(posedge clk); #1;
        idle_all();
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        do_reset();
        for (int r = 0; r < 4; r++) drive(r, 1'b0, 6'(10 + r), 8'h00);
        for (int c = 0; c < 4; c++) begin
            exp_rdy = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            @(negedge clk);
            n_checks++;
            if (req_ready !== exp_rdy) begin $display("FAIL rr_cycle%0d: got %b expected %b", c, req_ready, exp_rdy); n_fail++; end
            for (int r = 0; r < 4; r++) if (exp_rdy[r]) expect_acc(r, 1'b0, 6'(10 + r), 8'h00);
            @(posedge clk); #1;
        end
        idle_all();
        @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        do_reset();
        drive(1, 1'b1, 6'd40, 8'h77);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0010) begin $display("FAIL mid_write_ready: got %b expected 0010", req_ready); n_fail++; end
        expect_acc(1, 1'b1, 6'd40, 8'h77);
        @(posedge clk); #1;
        idle_all();
        #1;
        n_checks++;
        if (rsp_valid !== 4'b0010) begin $display("FAIL mid_rsp_before_reset: got %b expected 0010", rsp_valid); n_fail++; end
        rst_n = 1'b0;
        #1;
        due_q.delete();
        n_checks++;
        if ({rsp_valid, rsp_data} !== 36'd0) begin $display("FAIL mid_rsp_cleared: got %b %h expected 0000 0", rsp_valid, rsp_data); n_fail++; end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, 1'b0, 6'd40, 8'h00);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0001) begin $display("FAIL mid_read_ready: got %b expected 0001", req_ready); n_fail++; end
        expect_acc(0, 1'b0, 6'd40, 8'h00);
        @(posedge clk); #1;
        idle_all();
        n_checks++;
        if (rsp_data[7:0] !== 8'h77) begin $display("FAIL mid_read_data: got %h expected 77", rsp_data[7:0]); n_fail++; end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        do_reset();
        sb_en = 1'b0;
        drive(0, 1'b1, 6'd9, 8'h11);
        drive(1, 1'b0, 6'd9, 8'h00);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (conflict_cnt !== 16'hFFFE) begin $display("FAIL sat_before_top: got %h expected fffe", conflict_cnt); n_fail++; end
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (conflict_cnt !== 16'hFFFF) begin $display("FAIL sat_hold: got %h expected ffff", conflict_cnt); n_fail++; end
        shadow[9] = 8'h11;
        @(posedge clk); #1;
        idle_all();
        @(posedge clk); #1;
        pend_q.delete();
        due_q.delete();
        sb_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]    = 8'(i * 7 + 3);
            shadow[i] = 8'(i * 7 + 3);
        end
        mem[5]    = 8'h3C;
        shadow[5] = 8'h3C;
        test_reset();
        test_dual_grant();
        test_hazard();
        test_round_robin();
        test_reset_midstream();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
